// File: rtl/stage_fetch_decode_pt1_queue_pkg.sv
// rtl/stage_fetch_decode_pt1_queue_pkg.sv - entry type and helpers for the fetch/decode queue
`include "defines_cpu.vh"

package stage_fetch_decode_pt1_queue_pkg;

  typedef struct packed {
    logic [`ADDR_BUS]   pc;
    logic [`INST_BUS]   inst;
    logic [`EXCEPT_BUS] except;
  } fq_entry_t;

  // Value presented to decode when nothing valid is at the head.
  localparam fq_entry_t FQ_EMPTY = '{pc: `ZERO_32, inst: `ZERO_32, except: `EXC_NON};

  function automatic fq_entry_t fq_pack(input logic [`ADDR_BUS]   pc,
                                        input logic [`INST_BUS]   inst,
                                        input logic [`EXCEPT_BUS] except);
    fq_entry_t e;
    e.pc     = pc;
    e.inst   = inst;
    e.except = except;
    return e;
  endfunction

endpackage

// File: rtl/defines_cpu.vh
// rtl/defines_cpu.vh - shared CPU bus widths, codes and polarity constants
`ifndef DEFINES_CPU_VH
`define DEFINES_CPU_VH

`define ADDR_BUS          31:0
`define INST_BUS          31:0
`define EXCEPT_BUS        4:0
`define STALL_MODULE_BUS  1:0
`define EXC_NON           5'h00
`define ZERO_32           32'h0000_0000
`define RSTN_ENABLE       1'b0
`define TRUE_V            1'b1
`define FALSE_V           1'b0

`define FQ_DEPTH          4
`define FQ_PTR_BUS        1:0

`endif

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - DEPTH-entry register array, one write port, one async read port
`include "defines_cpu.vh"

module fetch_queue_mem
  import stage_fetch_decode_pt1_queue_pkg::*;
#(
  parameter int DEPTH = `FQ_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  fq_entry_t        wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output fq_entry_t        rdata_o
);

  fq_entry_t mem_q [DEPTH];

  // Storage is not reset; pointer/count state decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stage_fetch_decode_pt1_queue.sv
// rtl/stage_fetch_decode_pt1_queue.sv - fetch-to-decode-pt1 instruction queue (optional FE_QUEUE_BYPASS_EN)
`include "defines_cpu.vh"

module stage_fetch_decode_pt1_queue
  import stage_fetch_decode_pt1_queue_pkg::*;
#(
  parameter int DEPTH = `FQ_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic [`STALL_MODULE_BUS] stall_fe_de,
  input  logic                     fetch_valid,
  input  logic [`ADDR_BUS]         fetch_pc,
  input  logic [`INST_BUS]         fetch_inst,
  input  logic [`EXCEPT_BUS]       fetch_except,
  output logic                     queue_ready,
  output logic                     inst_valid_dept1,
  output logic [`ADDR_BUS]         pc_de_pt1,
  output logic [`INST_BUS]         inst_dept1,
  output logic [`EXCEPT_BUS]       except_type_dept1
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop, bypass, clear;
  fq_entry_t        fetch_entry, head_entry, out_entry;

  // Only stall_fe_de[1] gates the head; the downstream register handles its own bubble.
  logic unused_stall_lo;
  assign unused_stall_lo = stall_fe_de[0];

  assign clear       = (resetn == `RSTN_ENABLE) || (flush == `TRUE_V);
  assign fetch_entry = fq_pack(fetch_pc, fetch_inst, fetch_except);
  assign queue_ready = (count_q != FULL_CNT);

`ifdef FE_QUEUE_BYPASS_EN
  // Empty and unstalled: hand the fetched entry straight to decode without storing it.
  assign bypass = (count_q == '0) && fetch_valid && (stall_fe_de[1] == `FALSE_V) && !clear;
`else
  assign bypass = 1'b0;
`endif

  assign push = fetch_valid && queue_ready && !bypass;
  assign pop  = (count_q != '0) && (stall_fe_de[1] == `FALSE_V);

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && !clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (fetch_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Next pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Reset or flush empties the queue and discards any same-cycle push.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation: bypassed fetch, stored head, or the empty pattern.
  always_comb begin
    out_entry        = FQ_EMPTY;
    inst_valid_dept1 = 1'b0;
    if (bypass) begin
      out_entry        = fetch_entry;
      inst_valid_dept1 = 1'b1;
    end else if (count_q != '0) begin
      out_entry        = head_entry;
      inst_valid_dept1 = 1'b1;
    end
  end

  assign pc_de_pt1         = out_entry.pc;
  assign inst_dept1        = out_entry.inst;
  assign except_type_dept1 = out_entry.except;

endmodule

// File: doc/stage_fetch_decode_pt1_queue.md
Name: stage_fetch_decode_pt1_queue

Overview:
- Small instruction queue between the fetch stage and decode part 1.
- Absorbs fetched {pc, inst, except} triples while decode is stalled, so in-flight instruction-SRAM responses are never lost.
- Presents the oldest entry to decode part 1 in the same zero-bubble format used by the other stage registers.
- Flush or reset empties the queue.

Parameters:
DEPTH, 4, number of queue entries; must be a power of 2, at least 2.
PTR_W, 2, log2(DEPTH); width of the read and write pointers.

Ports:
clk  in  1  clock; all state updates on posedge.
resetn  in  1  synchronous active-low reset (`rstn_enable when asserted).
flush  in  1  exception/eret flush; empties the queue.
stall_fe_de  in  `stall_module_bus  [1]=decode pt1 stalled, [0]=stage after decode pt1 stalled.
fetch_valid  in  1  fetch offers an entry this cycle.
fetch_pc  in  `addr_bus  pc of the offered instruction.
fetch_inst  in  `inst_bus  instruction word.
fetch_except  in  `except_bus  exception code attached at fetch (`exc_non if none).
queue_ready  out  1  queue can accept a push this cycle.
inst_valid_dept1  out  1  head entry valid.
pc_de_pt1  out  `addr_bus  head pc.
inst_dept1  out  `inst_bus  head instruction.
except_type_dept1  out  `except_bus  head exception code.

Behaviour:
- State: storage array [DEPTH]; rd_ptr and wr_ptr (PTR_W bits); count (PTR_W+1 bits, range 0..DEPTH).
- Pointers wrap modulo DEPTH by natural overflow.
- queue_ready = (count != DEPTH). Combinational from count only; never depends on stall.
- push = fetch_valid & queue_ready.
- pop = (count != 0) & (stall_fe_de[1] == `false_v).
- stall_fe_de[0] is not used for pop; bubble insertion belongs to the downstream register.
- Precedence each posedge:
  1. resetn == `rstn_enable or flush == `true_v: rd_ptr = wr_ptr = count = 0. Any same-cycle push is discarded. Storage contents are don't-care.
  2. Otherwise push and pop apply independently.
     - count updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
     - Push when full is impossible because ready = 0, so the entry is not accepted and fetch must hold it.
     - Simultaneous push and pop at count == 1: the new entry becomes head next cycle.
- Outputs are combinational from the head entry:
  - count != 0: inst_valid_dept1 = 1, outputs = storage[rd_ptr].
  - count == 0: inst_valid_dept1 = 0, pc = `zero_32, inst = `zero_32, except = `exc_non.
  - Outputs therefore follow reset and flush from the cycle after the clearing edge.
- Latency: an entry pushed at edge N is visible on the outputs in the cycle after edge N, provided the queue was empty.
- Order: strict FIFO. Entries carrying a fetch exception are queued like any other entry.
- Stall held indefinitely: head and all outputs stay stable; once full, ready = 0.

Optional Feature:
- Macro: FE_QUEUE_BYPASS_EN.
- Defined: when count == 0, fetch_valid == 1 and stall_fe_de[1] == `false_v:
  - Outputs show the fetch_* inputs combinationally with inst_valid_dept1 = 1.
  - The entry is consumed without being written; pointers and count are unchanged.
  - Latency is 0. Flush or reset in that cycle still forces the outputs to the empty values.
- Undefined: no bypass; minimum latency 1 cycle.

Decomposition:
- defines_cpu.vh already holds `addr_bus, `inst_bus, `except_bus, `stall_module_bus, `exc_non, `zero_32, `rstn_enable, `true_v and `false_v.
- Add `fq_depth and `fq_ptr_bus to defines_cpu.vh.
- One sub-module: fetch_queue_mem, a DEPTH-entry register array with 1 write port (we, waddr, wdata) and 1 asynchronous read port.
- Pointer and count control stays in the top block.

Test Plan:
- Reset: resetn=0 for 2 cycles, fetch_valid=1 → count=0, inst_valid_dept1=0, pc/inst=0, except=`exc_non, queue_ready=1.
- Streaming: no stall, push pc 0xBFC00000/04/08 on consecutive cycles → outputs show each pc one cycle later in order, with count ≤1.
- Fill and hold: stall_fe_de=2'b10, push 5 entries pc 0x100..0x110 → 4 accepted, queue_ready=0 after the 4th, head pc=0x100 stable. Release stall → 0x100, 0x104, 0x108, 0x10C in order; the 0x110 entry is accepted once ready=1.
- Wrap-around: 10 interleaved push/pop sequences with random stalls → output order matches a reference FIFO model and count never exceeds 4.
- Flush: queue holds 3 entries and flush coincides with push pc 0x200 → next cycle count=0 and inst_valid=0; 0x200 never appears at the outputs.
- Exception entry: push fetch_except=`exc_adel (non-zero), pc 0x3 → exits with except_type_dept1=`exc_adel and pc 0x3 unchanged. With FE_QUEUE_BYPASS_EN, the same entry into an empty, unstalled queue appears in the same cycle.
